// File: rtl/window_burst_gen_if.sv
// Handshake/config bundle between a frame requester and window_burst_gen.
interface window_burst_gen_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] burst_off;
  logic [CNT_W-1:0] burst_len;
  logic             busy;
  logic             win;
  logic             done;
  logic             burst;
  logic             err;

  modport master (
    output start, win_len, burst_off, burst_len,
    input  busy, win, done, burst, err
  );

  modport slave (
    input  start, win_len, burst_off, burst_len,
    output busy, win, done, burst, err
  );
endinterface

// File: rtl/window_burst_gen.sv
// Window/done/burst frame generator: latches a config on start, validates it,
// then plays one frame of win_len window cycles plus a done cycle, with a
// burst strobe placed by burst_off/burst_len inside that span.
module window_burst_gen #(
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  window_burst_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wl_sh;
  logic [CNT_W-1:0] off_sh;
  logic [CNT_W-1:0] len_sh;

  logic [CNT_W:0]   req_sum;
  logic [CNT_W:0]   req_lim;
  logic             req_ok;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   burst_end;
  logic             burst_run;
  logic             burst_first;
  logic             last_win;

  // Request validation and next-cycle burst decode, all feeding registers.
  always_comb begin
    req_sum     = {1'b0, bus.burst_off} + {1'b0, bus.burst_len};
    req_lim     = {1'b0, bus.win_len} + (CNT_W+1)'(1);
    req_ok      = (bus.win_len != '0) && (bus.burst_len != '0) && (req_sum <= req_lim);
    burst_first = (bus.burst_off == '0);
    cnt_next    = cnt + CNT_W'(1);
    burst_end   = {1'b0, off_sh} + {1'b0, len_sh};
    burst_run   = ({1'b0, cnt_next} >= {1'b0, off_sh}) && ({1'b0, cnt_next} < burst_end);
    last_win    = (cnt == wl_sh - CNT_W'(1));
  end

  // Frame sequencer with registered outputs. FIN shares IDLE's start
  // handling so a request on the done cycle launches the next frame with
  // no idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wl_sh     <= '0;
      off_sh    <= '0;
      len_sh    <= '0;
      bus.busy  <= 1'b0;
      bus.win   <= 1'b0;
      bus.done  <= 1'b0;
      bus.burst <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          state     <= IDLE;
          cnt       <= '0;
          bus.busy  <= 1'b0;
          bus.win   <= 1'b0;
          bus.done  <= 1'b0;
          bus.burst <= 1'b0;
          if (bus.start) begin
            if (req_ok) begin
              wl_sh     <= bus.win_len;
              off_sh    <= bus.burst_off;
              len_sh    <= bus.burst_len;
              state     <= RUN;
              bus.busy  <= 1'b1;
              bus.win   <= 1'b1;
              bus.burst <= burst_first;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt       <= cnt_next;
          bus.burst <= burst_run;
          if (last_win) begin
            state    <= FIN;
            bus.win  <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bus.busy  <= 1'b0;
          bus.win   <= 1'b0;
          bus.done  <= 1'b0;
          bus.burst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_burst_gen.sv
// Bench for window_burst_gen: directed vector table, corner sequences and a
// randomized run, all checked against a frame-position reference model.
module tb_window_burst_gen;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window_burst_gen_if #(.CNT_W(W)) bus ();

  window_burst_gen #(.CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a frame is "active" with position m_n in 0..m_wl.
  bit m_act = 1'b0;
  int m_n   = 0;
  int m_wl  = 0;
  int m_off = 0;
  int m_len = 0;
  bit m_err = 1'b0;

  typedef struct {
    logic           rst;
    logic           start;
    logic [W-1:0]   wl;
    logic [W-1:0]   off;
    logic [W-1:0]   len;
    logic [4:0]     exp;   // {busy, win, done, burst, err}
  } vec_t;

  vec_t tbl [13];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit req_valid(int wl, int off, int len);
    return (wl >= 1) && (len >= 1) && (off + len <= wl + 1);
  endfunction

  // One clock: advance the model on the edge, then compare shortly after.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_act = 1'b0;
      m_n   = 0;
      m_err = 1'b0;
    end else if ((!m_act || m_n == m_wl) && bus.start) begin
      if (req_valid(int'(bus.win_len), int'(bus.burst_off), int'(bus.burst_len))) begin
        m_act = 1'b1;
        m_n   = 0;
        m_wl  = int'(bus.win_len);
        m_off = int'(bus.burst_off);
        m_len = int'(bus.burst_len);
        m_err = 1'b0;
      end else begin
        m_act = 1'b0;
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (m_act) begin
        if (m_n == m_wl) m_act = 1'b0;
        else m_n++;
      end
    end
    #1;
    chk("busy",  32'(bus.busy),  32'(m_act));
    chk("win",   32'(bus.win),   32'(m_act && m_n < m_wl));
    chk("done",  32'(bus.done),  32'(m_act && m_n == m_wl));
    chk("burst", 32'(bus.burst), 32'(m_act && m_n >= m_off && m_n < m_off + m_len));
    chk("err",   32'(bus.err),   32'(m_err));
  endtask

  task automatic drive(logic s, int wl, int off, int len);
    bus.start     = s;
    bus.win_len   = W'(wl);
    bus.burst_off = W'(off);
    bus.burst_len = W'(len);
  endtask

  int cnt_a;
  int cnt_b;
  int first_n;
  logic seen_last;

  initial begin
    drive(1'b0, 0, 0, 0);

    tbl[0]  = '{1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b1, 8'd3, 8'd0, 8'd4, 5'b11010};
    tbl[2]  = '{1'b0, 1'b0, 8'd3, 8'd0, 8'd4, 5'b11010};
    tbl[3]  = '{1'b0, 1'b0, 8'd3, 8'd0, 8'd4, 5'b11010};
    tbl[4]  = '{1'b0, 1'b0, 8'd3, 8'd0, 8'd4, 5'b10110};
    tbl[5]  = '{1'b0, 1'b0, 8'd3, 8'd0, 8'd4, 5'b00000};
    tbl[6]  = '{1'b0, 1'b1, 8'd3, 8'd1, 8'd4, 5'b00001};
    tbl[7]  = '{1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 5'b00000};
    tbl[8]  = '{1'b0, 1'b1, 8'd1, 8'd1, 8'd1, 5'b11000};
    tbl[9]  = '{1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 5'b10110};
    tbl[10] = '{1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 5'b00000};
    tbl[11] = '{1'b0, 1'b1, 8'd0, 8'd0, 8'd1, 5'b00001};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 5'b00000};

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].start, int'(tbl[i].wl), int'(tbl[i].off), int'(tbl[i].len));
      step();
      chk($sformatf("tbl%0d", i),
          32'({bus.busy, bus.win, bus.done, bus.burst, bus.err}), 32'(tbl[i].exp));
    end

    // start held high, win_len=2: one done every 3 cycles.
    drive(1'b1, 2, 0, 1);
    cnt_a = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.done) cnt_a++;
    end
    chk("b2b_done_count", 32'(cnt_a), 32'd3);
    drive(1'b0, 2, 0, 1);
    step();
    step();

    // Config change mid-frame must not affect the running frame.
    drive(1'b1, 5, 1, 2);
    step();
    drive(1'b0, 5, 0, 4);
    cnt_b = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.burst) cnt_b++;
    end
    chk("midchange_burst_len", 32'(cnt_b), 32'd2);

    // Reset on frame cycle 4 of a 10-cycle window.
    drive(1'b1, 10, 2, 3);
    step();
    drive(1'b0, 10, 2, 3);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    chk("rst_mid_outputs",
        32'({bus.busy, bus.win, bus.done, bus.burst, bus.err}), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_no_done", 32'(bus.done), 32'd0);
    drive(1'b1, 10, 2, 3);
    step();
    drive(1'b0, 10, 2, 3);
    cnt_a = 1;
    cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.busy) cnt_a++;
      if (bus.done) cnt_b++;
    end
    chk("post_rst_frame_len", 32'(cnt_a), 32'd11);
    chk("post_rst_done_count", 32'(cnt_b), 32'd1);

    // Maximum legal config: burst ends exactly on done.
    drive(1'b1, 255, 200, 56);
    step();
    drive(1'b0, 0, 0, 0);
    cnt_a     = 0;
    first_n   = -1;
    seen_last = 1'b0;
    for (int n = 0; n < 258; n++) begin
      if (bus.burst) begin
        cnt_a++;
        if (first_n < 0) first_n = n;
      end
      if (bus.done && bus.burst) seen_last = 1'b1;
      step();
    end
    chk("max_burst_len", 32'(cnt_a), 32'd56);
    chk("max_burst_first", 32'(first_n), 32'd200);
    chk("max_burst_on_done", 32'(seen_last), 32'd1);

    // Randomized run.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0)
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
      else
        drive($urandom_range(0, 2) == 0, $urandom_range(0, 6),
              $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
